// File: rtl/pb_conditioner.sv
// Push-button conditioner: per-button synchroniser, tick-based debounce,
// press/release edge pulses and a lowest-index press encoder.
module pb_conditioner #(
  parameter int NBTN        = 21,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 12000,
  parameter int DB_TICKS    = 10
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NBTN-1:0] pb,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] rel,
  output logic            key_valid,
  output logic [4:0]      key_idx,
  output logic            key_multi
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CLAST = CW'(DB_TICKS - 1);

  logic [SYNC_STAGES-1:0][NBTN-1:0] sync;
  logic [NBTN-1:0]                  s;
  logic [TW-1:0]                    tcnt;
  logic                             tick;
  logic [NBTN-1:0][CW-1:0]          cnt;
  logic [NBTN-1:0][CW-1:0]          cnt_n;
  logic [NBTN-1:0]                  level_n;
  logic [NBTN-1:0]                  press_n;
  logic [NBTN-1:0]                  rel_n;
  logic                             kv_n;
  logic                             km_n;
  logic [4:0]                       ki_n;

  assign s    = sync[SYNC_STAGES-1];
  assign tick = (tcnt == TLAST);

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      sync <= '0;
      tcnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pb};
      tcnt <= tick ? '0 : tcnt + TW'(1);
    end
  end

  // progress only advances on ticks; any agreeing cycle restarts it
  always_comb begin
    cnt_n   = cnt;
    level_n = level;
    press_n = '0;
    rel_n   = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (s[i] == level[i]) begin
        cnt_n[i] = '0;
      end else if (!tick) begin
        cnt_n[i] = cnt[i];
      end else if (cnt[i] < CLAST) begin
        cnt_n[i] = cnt[i] + CW'(1);
      end else begin
        cnt_n[i]   = '0;
        level_n[i] = s[i];
        press_n[i] = s[i];
        rel_n[i]   = !s[i];
      end
    end
  end

  always_comb begin
    kv_n = |press_n;
    km_n = |(press_n & (press_n - NBTN'(1)));
    ki_n = key_idx;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (press_n[i]) ki_n = 5'(i);
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      cnt       <= '0;
      level     <= '0;
      press     <= '0;
      rel       <= '0;
      key_valid <= 1'b0;
      key_idx   <= '0;
      key_multi <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      level     <= level_n;
      press     <= press_n;
      rel       <= rel_n;
      key_valid <= kv_n;
      key_idx   <= ki_n;
      key_multi <= km_n;
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random button traffic
// checked by a scoreboard fed from a tick-counting reference model.
module tb_pb_conditioner;

  localparam int NB = 21;
  localparam int TD = 4;
  localparam int DB = 3;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic [NB-1:0] pb = '0;
  logic [NB-1:0] level, press, rel;
  logic          key_valid, key_multi;
  logic [4:0]    key_idx;

  int ncmp = 0;
  int nbad = 0;

  pb_conditioner #(
    .NBTN(NB), .SYNC_STAGES(2), .TICK_DIV(TD), .DB_TICKS(DB)
  ) dut (
    .CLK(CLK), .nRST(nRST), .pb(pb),
    .level(level), .press(press), .rel(rel),
    .key_valid(key_valid), .key_idx(key_idx), .key_multi(key_multi)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [NB-1:0] p;
    logic [NB-1:0] r;
    logic [4:0]    idx;
    logic          multi;
  } ev_t;

  ev_t           q[$];
  logic [NB-1:0] mlevel = '0;
  logic [4:0]    mkidx = '0;
  logic [NB-1:0] ph0 = '0, ph1 = '0;
  int            k = 0;
  int            rs[NB];

  // A button flips once the synchronised value has disagreed with the
  // accepted level over a contiguous stretch containing DB ticks.
  initial begin
    forever begin
      @(posedge CLK or posedge nRST);
      if (nRST) begin
        k = 0; ph0 = '0; ph1 = '0; mlevel = '0; mkidx = '0;
        foreach (rs[i]) rs[i] = -1;
        q.delete();
      end else begin
        logic [NB-1:0] sv, p, r;
        int t;
        ev_t e;
        sv = ph1; p = '0; r = '0;
        for (int i = 0; i < NB; i++) begin
          if (sv[i] == mlevel[i]) begin
            rs[i] = -1;
          end else begin
            if (rs[i] < 0) rs[i] = k;
            t = (k + 1) / TD - rs[i] / TD;
            if (t >= DB) begin
              mlevel[i] = sv[i];
              p[i] = sv[i];
              r[i] = !sv[i];
              rs[i] = -1;
            end
          end
        end
        if (p != '0 || r != '0) begin
          e.p = p; e.r = r; e.idx = mkidx;
          e.multi = ($countones(p) > 1);
          for (int i = NB - 1; i >= 0; i--) if (p[i]) e.idx = 5'(i);
          mkidx = e.idx;
          q.push_back(e);
        end
        ph1 = ph0; ph0 = pb; k++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        ev_t e;
        chk("level", 32'(level), 32'(mlevel));
        chk("key_idx_held", 32'(key_idx), 32'(mkidx));
        chk("press_rel_overlap", 32'(press & rel), 32'(0));
        if (press != '0 || rel != '0 || key_valid || key_multi) begin
          if (q.size() == 0) begin
            chk("unexpected_event", 32'(press | rel), 32'(0));
          end else begin
            e = q.pop_front();
            chk("ev_press", 32'(press), 32'(e.p));
            chk("ev_release", 32'(rel), 32'(e.r));
            chk("ev_key_valid", 32'(key_valid), 32'(e.p != '0));
            chk("ev_key_multi", 32'(key_multi), 32'(e.multi));
          end
        end else if (q.size() != 0) begin
          e = q.pop_front();
          chk("missed_event", 32'(0), 32'(e.p | e.r));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, cntp, bad;
    logic seen;
    cyc(3);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_pulses", 32'(press | rel), 32'(0));
    chk("rst_key", 32'({key_valid, key_idx, key_multi}), 32'(0));
    nRST = 1'b0;
    cyc(5);

    // single clean press
    pb[3] = 1'b1;
    n = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK); n++;
      if (level[3]) break;
    end
    chk("t1_latency_ok", 32'(n >= 11 && n <= 14), 32'(1));
    chk("t1_press3", 32'(press), 32'(1 << 3));
    chk("t1_kv_idx_multi", 32'({key_valid, key_idx, key_multi}),
        32'({1'b1, 5'd3, 1'b0}));
    @(negedge CLK);
    chk("t1_pulse_width", 32'({press[3], key_valid}), 32'(0));
    pb[3] = 1'b0;
    cyc(20);

    // short pulse filtered out
    bad = 0;
    for (int j = 0; j < 33; j++) begin
      if (j == 0) pb[5] = 1'b1;
      if (j == 8) pb[5] = 1'b0;
      @(negedge CLK);
      if (level[5] || press[5] || key_valid) bad++;
    end
    chk("t2_filtered", 32'(bad), 32'(0));

    // bounce then settle high
    cntp = 0;
    for (int j = 0; j < 20; j++) begin
      pb[3] = j[0];
      @(negedge CLK);
      if (press[3]) cntp++;
    end
    pb[3] = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge CLK);
      if (press[3]) cntp++;
    end
    chk("t3_single_press", 32'(cntp), 32'(1));
    chk("t3_level3", 32'(level[3]), 32'(1));
    pb[3] = 1'b0;
    cyc(20);

    // simultaneous press / release
    pb[2] = 1'b1; pb[7] = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (key_valid) begin seen = 1'b1; break; end
    end
    chk("t4_kv_seen", 32'(seen), 32'(1));
    chk("t4_press_both", 32'(press), 32'((1 << 2) | (1 << 7)));
    chk("t4_idx_multi", 32'({key_idx, key_multi}), 32'({5'd2, 1'b1}));
    pb[2] = 1'b0; pb[7] = 1'b0;
    seen = 1'b0; cntp = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (rel[2] && rel[7]) seen = 1'b1;
      if (key_valid) cntp++;
    end
    chk("t4_release_both", 32'(seen), 32'(1));
    chk("t4_no_kv_on_release", 32'(cntp), 32'(0));

    // reset while a button is held
    pb[0] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (level[0]) break;
    end
    chk("t5_level0", 32'(level[0]), 32'(1));
    cyc(3);
    #3 nRST = 1'b1;
    #1;
    chk("t5_async_level", 32'(level), 32'(0));
    chk("t5_async_key", 32'({press, rel, key_valid, key_idx, key_multi}), 32'(0));
    @(negedge CLK);
    nRST = 1'b0;
    n = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK); n++;
      if (press[0]) break;
    end
    chk("t5_repress_latency_ok", 32'(n >= 11 && n <= 14), 32'(1));
    pb = '0;
    cyc(20);

    // highest index, then held through idle
    pb[20] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (key_valid) break;
    end
    chk("t6_idx20", 32'({key_valid, key_idx}), 32'({1'b1, 5'd20}));
    cyc(10);
    chk("t6_idx20_held", 32'({key_valid, key_idx}), 32'({1'b0, 5'd20}));
    pb = '0;
    cyc(20);

    // random traffic
    for (int it = 0; it < 120; it++) begin
      logic [NB-1:0] m;
      int g;
      m = NB'($urandom) & NB'($urandom) & NB'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 9);
        for (int b = 0; b < g; b++) begin
          pb ^= m;
          @(negedge CLK);
        end
      end else begin
        pb ^= m;
        cyc($urandom_range(1, 25));
      end
    end
    pb = '0;
    cyc(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
